acq_sequencer: RTL and testbench

Acquisition controller that sequences the four-channel APD timestamp timer. On a host start command it optionally clears the timer's counter, opens an acquisition window by holding `operate`, and closes it on one of four events: host stop, elapsed duration, record limit, or FIFO overflow. It then drains in-flight records and reports status. It sits between the host register file and the timer/latch block, and drives that block's `operate` and `reset_counter` inputs directly.

---
 rtl/acq_seq_pkg.sv | 27 ++
 rtl/sat_counter.sv | 29 ++
 rtl/acq_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_acq_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_seq_pkg.sv
// Shared types and constants for the acquisition sequencer.
// No logic; types, stop-reason codes and a width helper only.
// Not applicable (no datapath).
package acq_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Stop-reason codes reported on stop_reason
    localparam logic [1:0] REASON_HOST     = 2'd0;
    localparam logic [1:0] REASON_DURATION = 2'd1;
    localparam logic [1:0] REASON_LIMIT    = 2'd2;
    localparam logic [1:0] REASON_OVERFLOW = 2'd3;

    // Width of a down-phase counter able to hold max(a, b) - 1
    function automatic int unsigned phase_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear wins over inc.
// Value updates one cycle after clear/inc.
// No backpressure; inc is accepted every cycle.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    // Count up on inc, hold at all-ones, restart on clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (inc && (r_value != {WIDTH{1'b1}})) begin
            r_value <= r_value + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign value = r_value;

endmodule

// File: rtl/acq_sequencer.sv
// Sequences the APD timer: optional counter clear, acquisition window, drain, status.
// All outputs registered; operate rises 1 cycle after start (or after CLR_CYCLES of clear).
// No backpressure; fifo_full only terminates the run and flags overflow.
module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int DUR_W        = 32,
    parameter int CNT_W        = 32,
    parameter int CLR_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_cmd,
    input  logic             stop_cmd,
    input  logic             timed_mode,
    input  logic             clear_on_start,
    input  logic [DUR_W-1:0] duration,
    input  logic [CNT_W-1:0] record_limit,
    input  logic             data_rdy,
    input  logic             fifo_full,
    output logic             operate,
    output logic             reset_counter,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [1:0]       stop_reason,
    output logic [CNT_W-1:0] record_count,
    output logic [DUR_W-1:0] elapsed
);

    localparam int PH_W = phase_width(CLR_CYCLES, DRAIN_CYCLES);
    localparam logic [PH_W-1:0] CLR_LAST   = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [PH_W-1:0]   r_phase;
    logic              r_timed;
    logic [DUR_W-1:0]  r_duration;
    logic [CNT_W-1:0]  r_limit;

    logic              r_operate;
    logic              r_reset_counter;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic [1:0]        r_stop_reason;

    logic              w_accept;
    logic              w_rec_phase;
    logic              w_ovf_evt;
    logic              w_dur_hit;
    logic              w_lim_hit;
    logic              w_set_reason;
    logic [1:0]        w_reason;

    // A timed start with zero duration would never open a window, so it is dropped
    assign w_accept    = (r_state == IDLE) && start_cmd && !(timed_mode && (duration == '0));
    assign w_rec_phase = (r_state == RUN) || (r_state == DRAIN);
    assign w_ovf_evt   = w_rec_phase && data_rdy && fifo_full;
    // elapsed still shows the count before this cycle, hence the minus one
    assign w_dur_hit   = r_timed && (elapsed == (r_duration - {{(DUR_W-1){1'b0}}, 1'b1}));
    assign w_lim_hit   = (r_limit != '0) && data_rdy &&
                         (record_count == (r_limit - {{(CNT_W-1){1'b0}}, 1'b1}));

    // Next state and stop reason selection
    always_comb begin
        w_next_state = r_state;
        w_set_reason = 1'b0;
        w_reason     = REASON_HOST;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = clear_on_start ? CLEAR : RUN;
                end
            end
            CLEAR: begin
                // stop_reason was zeroed at start, so a host abort needs no reason write
                if (stop_cmd) begin
                    w_next_state = IDLE;
                end else if (r_phase == CLR_LAST) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (data_rdy && fifo_full) begin
                    w_next_state = DRAIN;
                    w_set_reason = 1'b1;
                    w_reason     = REASON_OVERFLOW;
                end else if (stop_cmd) begin
                    w_next_state = DRAIN;
                    w_set_reason = 1'b1;
                    w_reason     = REASON_HOST;
                end else if (w_dur_hit) begin
                    w_next_state = DRAIN;
                    w_set_reason = 1'b1;
                    w_reason     = REASON_DURATION;
                end else if (w_lim_hit) begin
                    w_next_state = DRAIN;
                    w_set_reason = 1'b1;
                    w_reason     = REASON_LIMIT;
                end
            end
            DRAIN: begin
                if (r_phase == DRAIN_LAST) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and phase counter for the fixed-length CLEAR/DRAIN states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || !((r_state == CLEAR) || (r_state == DRAIN))) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + {{(PH_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Run configuration captured on an accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timed    <= 1'b0;
            r_duration <= '0;
            r_limit    <= '0;
        end else if (w_accept) begin
            r_timed    <= timed_mode;
            r_duration <= duration;
            r_limit    <= record_limit;
        end
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_operate       <= 1'b0;
            r_reset_counter <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_operate       <= (w_next_state == RUN);
            r_reset_counter <= (w_next_state == CLEAR);
            r_busy          <= (w_next_state != IDLE);
            r_done          <= (r_state != IDLE) && (w_next_state == IDLE);
        end
    end

    // Run status: cleared by a new start, otherwise held after the run ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_stop_reason <= REASON_HOST;
        end else if (w_accept) begin
            r_overflow    <= 1'b0;
            r_stop_reason <= REASON_HOST;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
            if (w_set_reason) begin
                r_stop_reason <= w_reason;
            end
        end
    end

    sat_counter #(.WIDTH(DUR_W)) u_elapsed (
        .clk   (clk),
        .reset (reset),
        .clear (w_accept),
        .inc   (r_state == RUN),
        .value (elapsed)
    );

    // Records are counted through DRAIN too, so the count may exceed the limit
    sat_counter #(.WIDTH(CNT_W)) u_record_count (
        .clk   (clk),
        .reset (reset),
        .clear (w_accept),
        .inc   (w_rec_phase && data_rdy),
        .value (record_count)
    );

    assign operate       = r_operate;
    assign reset_counter = r_reset_counter;
    assign busy          = r_busy;
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign stop_reason   = r_stop_reason;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed scenarios plus randomized runs
// compared against a run-level reference model. Cycle k of a run is the clock
// period after the k-th rising edge following the start cycle (k = 0).
module tb_acq_sequencer;

    localparam int CLR  = 4;
    localparam int DRN  = 8;
    localparam int NMAX = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_cmd = 1'b0;
    logic        stop_cmd = 1'b0;
    logic        timed_mode = 1'b0;
    logic        clear_on_start = 1'b0;
    logic [31:0] duration = '0;
    logic [31:0] record_limit = '0;
    logic        data_rdy = 1'b0;
    logic        fifo_full = 1'b0;
    logic        operate, reset_counter, busy, done, overflow;
    logic [1:0]  stop_reason;
    logic [31:0] record_count, elapsed;

    acq_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start_cmd      (start_cmd),
        .stop_cmd       (stop_cmd),
        .timed_mode     (timed_mode),
        .clear_on_start (clear_on_start),
        .duration       (duration),
        .record_limit   (record_limit),
        .data_rdy       (data_rdy),
        .fifo_full      (fifo_full),
        .operate        (operate),
        .reset_counter  (reset_counter),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow),
        .stop_reason    (stop_reason),
        .record_count   (record_count),
        .elapsed        (elapsed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus of one run
    bit dr_a [NMAX];
    bit ff_a [NMAX];
    bit st_a [NMAX];
    bit sp_a [NMAX];

    // Observed summary of one run
    int op_first, op_last, op_cnt, rc_first, rc_last, rc_cnt;
    int done_cyc, done_cnt, busy_cnt;
    int s_reason, s_count, s_elapsed, s_ovf;

    // Expected summary from the reference model
    int e_op_first, e_op_last, e_op_cnt, e_rc_cnt, e_done, e_done_cnt, e_busy_cnt;
    int e_reason, e_count, e_elapsed, e_ovf;

    task automatic clear_stim();
        for (int k = 0; k < NMAX; k++) begin
            dr_a[k] = 1'b0; ff_a[k] = 1'b0; st_a[k] = 1'b0; sp_a[k] = 1'b0;
        end
        st_a[0] = 1'b1;
    endtask

    // Plays the stimulus arrays for ncyc cycles and summarises what the DUT did
    task automatic run_capture(input bit clr, input bit timed, input int dur, input int lim, input int ncyc);
        op_first = -1; op_last = -1; op_cnt = 0; rc_first = -1; rc_last = -1; rc_cnt = 0;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        s_reason = 0; s_count = 0; s_elapsed = 0; s_ovf = 0;
        clear_on_start = clr; timed_mode = timed; duration = 32'(dur); record_limit = 32'(lim);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (operate) begin
                if (op_first < 0) op_first = k;
                op_last = k; op_cnt++;
            end
            if (reset_counter) begin
                if (rc_first < 0) rc_first = k;
                rc_last = k; rc_cnt++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k; s_reason = int'(stop_reason); s_count = int'(record_count);
                    s_elapsed = int'(elapsed); s_ovf = int'(overflow);
                end
            end
            start_cmd = st_a[k]; stop_cmd = sp_a[k]; data_rdy = dr_a[k]; fifo_full = ff_a[k];
        end
        @(negedge clk);
        start_cmd = 1'b0; stop_cmd = 1'b0; data_rdy = 1'b0; fifo_full = 1'b0;
    endtask

    // Run-level model: walks the window index by index using the documented exit rules
    task automatic model_predict(input bit clr, input bit timed, input int dur, input int lim);
        int rs, cnt, ovf, e, rsn;
        e_op_first = -1; e_op_last = -1; e_op_cnt = 0; e_rc_cnt = 0; e_done = -1; e_done_cnt = 0;
        e_busy_cnt = 0; e_reason = 0; e_count = 0; e_elapsed = 0; e_ovf = 0;
        if (timed && dur == 0) return;
        e_done_cnt = 1;
        rs = clr ? 1 + CLR : 1;
        if (clr) begin
            for (int k = 1; k <= CLR; k++) begin
                if (sp_a[k]) begin
                    e_rc_cnt = k; e_done = k + 1; e_busy_cnt = k;
                    return;
                end
            end
            e_rc_cnt = CLR;
        end
        cnt = 0; ovf = 0; e = -1;
        for (int k = rs; k < NMAX - DRN - 1 && e < 0; k++) begin
            rsn = -1;
            if (dr_a[k] && ff_a[k])                     rsn = 3;
            else if (sp_a[k])                           rsn = 0;
            else if (timed && (k - rs + 1) == dur)      rsn = 1;
            else if (lim != 0 && dr_a[k] && cnt + 1 == lim) rsn = 2;
            if (dr_a[k]) cnt++;
            if (dr_a[k] && ff_a[k]) ovf = 1;
            if (rsn >= 0) begin e = k; e_reason = rsn; end
        end
        for (int k = e + 1; k <= e + DRN; k++) begin
            if (dr_a[k]) cnt++;
            if (dr_a[k] && ff_a[k]) ovf = 1;
        end
        e_op_first = rs; e_op_last = e; e_op_cnt = e - rs + 1;
        e_done = e + DRN + 1; e_busy_cnt = e_done - 1;
        e_count = cnt; e_elapsed = e - rs + 1; e_ovf = ovf;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({operate, reset_counter, busy, done, overflow} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {operate, reset_counter, busy, done, overflow}); end
        checks++; if ({stop_reason, record_count, elapsed} !== 66'd0) begin errors++; $display("FAIL reset_status: got reason %0d count %0d elapsed %0d want 0", stop_reason, record_count, elapsed); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({operate, busy, done} !== 3'b0) begin errors++; $display("FAIL reset_release: got %b want 000", {operate, busy, done}); end
    endtask

    task automatic test_clear_timed();
        clear_stim();
        run_capture(1'b1, 1'b1, 100, 0, 130);
        checks++; if (rc_first !== 1 || rc_last !== 4 || rc_cnt !== 4) begin errors++; $display("FAIL clr_window: got %0d..%0d n=%0d want 1..4 n=4", rc_first, rc_last, rc_cnt); end
        checks++; if (op_first !== 5 || op_last !== 104 || op_cnt !== 100) begin errors++; $display("FAIL op_window: got %0d..%0d n=%0d want 5..104 n=100", op_first, op_last, op_cnt); end
        checks++; if (done_cyc !== 113) begin errors++; $display("FAIL timed_done: got %0d want 113", done_cyc); end
        checks++; if (busy_cnt !== 112) begin errors++; $display("FAIL timed_busy: got %0d want 112", busy_cnt); end
        checks++; if (s_elapsed !== 100 || s_reason !== 1) begin errors++; $display("FAIL timed_status: got elapsed %0d reason %0d want 100 1", s_elapsed, s_reason); end
    endtask

    task automatic test_record_limit();
        clear_stim();
        for (int k = 3; k < 60; k += 3) dr_a[k] = 1'b1;
        run_capture(1'b0, 1'b0, 0, 5, 40);
        checks++; if (op_last !== 15 || s_reason !== 2) begin errors++; $display("FAIL limit_stop: got last %0d reason %0d want 15 2", op_last, s_reason); end
        checks++; if (!(s_count == 7 || s_count == 8)) begin errors++; $display("FAIL limit_drain_count: got %0d want 7 or 8", s_count); end
        checks++; if (done_cyc !== 24) begin errors++; $display("FAIL limit_done: got %0d want 24", done_cyc); end
    endtask

    task automatic test_overflow();
        clear_stim();
        dr_a[2] = 1'b1; dr_a[4] = 1'b1; dr_a[6] = 1'b1; ff_a[6] = 1'b1;
        run_capture(1'b0, 1'b0, 0, 0, 25);
        checks++; if (s_ovf !== 1 || s_reason !== 3 || s_count !== 3) begin errors++; $display("FAIL ovf_status: got ovf %0d reason %0d count %0d want 1 3 3", s_ovf, s_reason, s_count); end
        checks++; if (op_last !== 6) begin errors++; $display("FAIL ovf_stop: got %0d want 6", op_last); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
        clear_stim();
        sp_a[3] = 1'b1;
        run_capture(1'b0, 1'b0, 0, 0, 20);
        checks++; if (s_ovf !== 0 || s_reason !== 0) begin errors++; $display("FAIL ovf_cleared: got ovf %0d reason %0d want 0 0", s_ovf, s_reason); end
    endtask

    task automatic test_host_stop_clear();
        clear_stim();
        sp_a[2] = 1'b1;
        run_capture(1'b1, 1'b0, 0, 0, 15);
        checks++; if (done_cyc !== 3 || done_cnt !== 1) begin errors++; $display("FAIL abort_done: got cyc %0d n=%0d want 3 n=1", done_cyc, done_cnt); end
        checks++; if (op_cnt !== 0 || busy_cnt !== 2) begin errors++; $display("FAIL abort_run: got op %0d busy %0d want 0 2", op_cnt, busy_cnt); end
        checks++; if (s_reason !== 0) begin errors++; $display("FAIL abort_reason: got %0d want 0", s_reason); end
    endtask

    task automatic test_command_edges();
        // start while running
        clear_stim();
        st_a[8] = 1'b1; sp_a[20] = 1'b1;
        run_capture(1'b1, 1'b0, 0, 0, 40);
        checks++; if (rc_cnt !== 4 || op_first !== 5 || op_last !== 20) begin errors++; $display("FAIL start_in_run: got rc %0d op %0d..%0d want 4 5..20", rc_cnt, op_first, op_last); end
        checks++; if (done_cyc !== 29 || s_elapsed !== 16) begin errors++; $display("FAIL start_in_run_status: got done %0d elapsed %0d want 29 16", done_cyc, s_elapsed); end
        // timed start with zero duration
        clear_stim();
        run_capture(1'b1, 1'b1, 0, 0, 20);
        checks++; if (busy_cnt !== 0 || rc_cnt !== 0 || op_cnt !== 0 || done_cnt !== 0) begin errors++; $display("FAIL zero_dur: got busy %0d rc %0d op %0d done %0d want 0", busy_cnt, rc_cnt, op_cnt, done_cnt); end
        checks++; if (elapsed !== 32'd16) begin errors++; $display("FAIL zero_dur_status: got elapsed %0d want 16", elapsed); end
        // start and stop together in IDLE
        clear_stim();
        sp_a[0] = 1'b1; sp_a[10] = 1'b1;
        run_capture(1'b0, 1'b0, 0, 0, 30);
        checks++; if (op_first !== 1 || op_last !== 10 || done_cyc !== 19) begin errors++; $display("FAIL start_stop_same: got op %0d..%0d done %0d want 1..10 19", op_first, op_last, done_cyc); end
    endtask

    task automatic test_async_reset();
        int dn;
        clear_stim();
        run_capture(1'b0, 1'b0, 0, 0, 10);
        checks++; if (operate !== 1'b1) begin errors++; $display("FAIL areset_pre: got operate %0b want 1", operate); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (operate !== 1'b0) begin errors++; $display("FAIL areset_operate: got %0b want 0", operate); end
        checks++; if ({reset_counter, busy, done, overflow, stop_reason, record_count, elapsed} !== 70'd0) begin errors++; $display("FAIL areset_outputs: got busy %0b elapsed %0d want 0", busy, elapsed); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        checks++; if (dn !== 0 || busy !== 1'b0) begin errors++; $display("FAIL areset_no_done: got done %0d busy %0b want 0 0", dn, busy); end
    endtask

    task automatic test_random();
        bit clr, timed;
        int dur, lim;
        for (int r = 0; r < 30; r++) begin
            clear_stim();
            clr   = 1'($urandom_range(0, 1));
            timed = 1'($urandom_range(0, 1));
            dur   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            lim   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
            for (int k = 1; k < NMAX; k++) begin
                dr_a[k] = ($urandom_range(0, 99) < 30);
                ff_a[k] = dr_a[k] && ($urandom_range(0, 99) < 5);
                sp_a[k] = ($urandom_range(0, 99) < 1);
            end
            sp_a[150] = 1'b1;
            model_predict(clr, timed, dur, lim);
            run_capture(clr, timed, dur, lim, 180);
            checks++; if (op_first !== e_op_first || op_last !== e_op_last || op_cnt !== e_op_cnt) begin errors++; $display("FAIL rnd%0d operate: got %0d..%0d n=%0d want %0d..%0d n=%0d", r, op_first, op_last, op_cnt, e_op_first, e_op_last, e_op_cnt); end
            checks++; if (rc_cnt !== e_rc_cnt) begin errors++; $display("FAIL rnd%0d reset_counter: got %0d want %0d", r, rc_cnt, e_rc_cnt); end
            checks++; if (done_cyc !== e_done || done_cnt !== e_done_cnt) begin errors++; $display("FAIL rnd%0d done: got %0d n=%0d want %0d n=%0d", r, done_cyc, done_cnt, e_done, e_done_cnt); end
            checks++; if (busy_cnt !== e_busy_cnt) begin errors++; $display("FAIL rnd%0d busy: got %0d want %0d", r, busy_cnt, e_busy_cnt); end
            checks++; if (s_reason !== e_reason || s_count !== e_count) begin errors++; $display("FAIL rnd%0d reason_count: got %0d %0d want %0d %0d", r, s_reason, s_count, e_reason, e_count); end
            checks++; if (s_elapsed !== e_elapsed || s_ovf !== e_ovf) begin errors++; $display("FAIL rnd%0d elapsed_ovf: got %0d %0d want %0d %0d", r, s_elapsed, s_ovf, e_elapsed, e_ovf); end
        end
    endtask

    initial begin
        test_reset();
        test_clear_timed();
        test_record_limit();
        test_overflow();
        test_host_stop_clear();
        test_command_edges();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
